// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types for the two-master I/O bus arbiter.
package io_bus_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;
    typedef struct packed {
        logic              wr;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } io_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant, round-robin or fixed m0 priority, one-hot result.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    always_comb gnt = (req == 2'b11) ? ((FIXED_PRIO != 0 || last_grant) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the OR-combined I/O bus between two masters,
// one transaction at a time, with registered strobes, acks and read data.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int READ_LATENCY = 0,
    parameter int FIXED_PRIO   = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_dout,
    output logic          s_rd,
    output logic          s_wr,
    input  logic [DW-1:0] s_din
);
    localparam bit         HAS_WAIT = READ_LATENCY > 0;
    localparam logic [2:0] RL_M1    = 3'(HAS_WAIT ? READ_LATENCY - 1 : 0);

    state_t        state, nxt_state;
    io_req_t       cur, nxt_cur, win;
    logic          last_grant, nxt_last;
    logic [2:0]    cnt, nxt_cnt;
    logic [1:0]    gnt, nxt_ack;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_dout, nxt_rdata0, nxt_rdata1;
    logic          nxt_rd, nxt_wr, fin;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_comb win = gnt[1] ? '{wr: m1_wr, addr: AW_DEF'(m1_addr), wdata: DW_DEF'(m1_wdata)}
                             : '{wr: m0_wr, addr: AW_DEF'(m0_addr), wdata: DW_DEF'(m0_wdata)};

    always_comb begin
        nxt_state  = state;
        nxt_cur    = cur;
        nxt_last   = last_grant;
        nxt_cnt    = cnt;
        nxt_addr   = '0;
        nxt_dout   = '0;
        nxt_rd     = 1'b0;
        nxt_wr     = 1'b0;
        nxt_ack    = 2'b00;
        nxt_rdata0 = m0_rdata;
        nxt_rdata1 = m1_rdata;
        fin        = 1'b0;
        case (state)
            IDLE: if (|gnt) begin
                nxt_state = XFER;
                nxt_cur   = win;
                nxt_last  = gnt[1];
                nxt_addr  = AW'(win.addr);
                nxt_dout  = DW'(win.wdata);
                nxt_wr    = win.wr;
                nxt_rd    = !win.wr;
            end
            XFER: if (cur.wr || !HAS_WAIT) begin
                fin = 1'b1;
            end else begin
                nxt_state = WAIT;
                nxt_cnt   = RL_M1;
                nxt_addr  = AW'(cur.addr);
                nxt_dout  = DW'(cur.wdata);
            end
            WAIT: if (cnt == 3'd0) begin
                fin = 1'b1;
            end else begin
                nxt_cnt  = cnt - 3'd1;
                nxt_addr = AW'(cur.addr);
                nxt_dout = DW'(cur.wdata);
            end
            default: nxt_state = IDLE;
        endcase
        // last_grant always names the current owner, so it steers ack and rdata
        if (fin) begin
            nxt_state  = DONE;
            nxt_ack    = last_grant ? 2'b10 : 2'b01;
            nxt_rdata0 = (!cur.wr && !last_grant) ? s_din : m0_rdata;
            nxt_rdata1 = (!cur.wr && last_grant) ? s_din : m1_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= 1'b1;
            cnt        <= '0;
            s_addr     <= '0;
            s_dout     <= '0;
            s_rd       <= 1'b0;
            s_wr       <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state      <= nxt_state;
            cur        <= nxt_cur;
            last_grant <= nxt_last;
            cnt        <= nxt_cnt;
            s_addr     <= nxt_addr;
            s_dout     <= nxt_dout;
            s_rd       <= nxt_rd;
            s_wr       <= nxt_wr;
            m0_ack     <= nxt_ack[0];
            m1_ack     <= nxt_ack[1];
            m0_rdata   <= nxt_rdata0;
            m1_rdata   <= nxt_rdata1;
        end
    end

    a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n) !(s_rd && s_wr));
    a_one_ack:    assert property (@(posedge clk) disable iff (!reset_n) !(m0_ack && m1_ack));
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed checks on three arbiter instances
// (RL=0 round-robin, RL=3 round-robin, RL=0 fixed priority) sharing one stimulus.
module tb_io_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, s_din = '0;
    logic [2:0] ack0, ack1, srd, swr;
    logic [2:0][15:0] rd0, rd1, sa, sd;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        io_bus_arbiter #(
            .AW(16), .DW(16),
            .READ_LATENCY(i == 1 ? 3 : 0),
            .FIXED_PRIO(i == 2 ? 1 : 0)
        ) dut (
            .clk(clk), .reset_n(reset_n),
            .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_ack(ack0[i]), .m0_rdata(rd0[i]),
            .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_ack(ack1[i]), .m1_rdata(rd1[i]),
            .s_addr(sa[i]), .s_dout(sd[i]), .s_rd(srd[i]), .s_wr(swr[i]), .s_din(s_din)
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        m0_req = 1'b0;
        m1_req = 1'b0;
        s_din  = '0;
        repeat (8) tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({ack0[i], ack1[i], srd[i], swr[i], sa[i], sd[i], rd0[i], rd1[i]} !== '0) begin
                fails++;
                $display("FAIL reset dut%0d: outputs %h, expected all 0", i,
                         {ack0[i], ack1[i], srd[i], swr[i], sa[i], sd[i], rd0[i], rd1[i]});
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0010; m0_wdata = 16'hBEEF;
        tick();
        tests++;
        if ({swr[0], srd[0], sa[0], sd[0], ack0[0]} !== {1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0}) begin
            fails++;
            $display("FAIL write_strobe: wr=%b rd=%b addr=%h dout=%h ack=%b, expected 1 0 0010 beef 0",
                     swr[0], srd[0], sa[0], sd[0], ack0[0]);
        end
        tick();
        tests++;
        if ({ack0[0], ack1[0], swr[0], sa[0], sd[0]} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            fails++;
            $display("FAIL write_ack: ack0=%b ack1=%b wr=%b addr=%h dout=%h, expected 1 0 0 0000 0000",
                     ack0[0], ack1[0], swr[0], sa[0], sd[0]);
        end
        m0_req = 1'b0;
        tick();
        tests++;
        if (ack0[0] !== 1'b0) begin
            fails++;
            $display("FAIL write_ack_pulse: ack0=%b, expected 0", ack0[0]);
        end
        settle();
    endtask

    task automatic test_read;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0020;
        tick();
        tests++;
        if ({srd[0], swr[0], sa[0]} !== {1'b1, 1'b0, 16'h0020}) begin
            fails++;
            $display("FAIL read_strobe: rd=%b wr=%b addr=%h, expected 1 0 0020", srd[0], swr[0], sa[0]);
        end
        s_din = 16'h1234;
        tick();
        tests++;
        if ({ack1[0], ack0[0], rd1[0]} !== {1'b1, 1'b0, 16'h1234}) begin
            fails++;
            $display("FAIL read_ack: ack1=%b ack0=%b rdata1=%h, expected 1 0 1234", ack1[0], ack0[0], rd1[0]);
        end
        settle();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ack;
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0100; m0_wdata = 16'h0001;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0200; m1_wdata = 16'h0002;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_ack = {k == 2 || k == 8, k == 5 || k == 11, k == 2 || k == 5 || k == 8, k == 11};
            tests++;
            if ({ack0[0], ack1[0], ack0[2], ack1[2]} !== exp_ack) begin
                fails++;
                $display("FAIL rr_acks cycle %0d: rr{a0,a1}=%b%b fixed{a0,a1}=%b%b, expected %b",
                         k, ack0[0], ack1[0], ack0[2], ack1[2], exp_ack);
            end
            if (k % 3 == 1) begin
                tests++;
                if (sa[0] !== ((k % 2 == 1) ? 16'h0100 : 16'h0200)) begin
                    fails++;
                    $display("FAIL rr_addr cycle %0d: addr=%h, expected %h", k, sa[0],
                             (k % 2 == 1) ? 16'h0100 : 16'h0200);
                end
            end
            if (k == 8) m0_req = 1'b0;
        end
        settle();
    endtask

    task automatic test_read_latency;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0030; s_din = 16'h5A5A;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if ({srd[1], swr[1], ack0[1], ack1[1], sa[1]} !==
                {k == 1, 1'b0, k == 5, 1'b0, (k < 5) ? 16'h0030 : 16'h0000}) begin
                fails++;
                $display("FAIL rl3 cycle %0d: rd=%b wr=%b ack0=%b ack1=%b addr=%h, expected %b 0 %b 0 %h",
                         k, srd[1], swr[1], ack0[1], ack1[1], sa[1], k == 1, k == 5,
                         (k < 5) ? 16'h0030 : 16'h0000);
            end
            s_din = (k == 4) ? 16'hA5A5 : 16'h5A5A;
        end
        tests++;
        if (rd0[1] !== 16'hA5A5) begin
            fails++;
            $display("FAIL rl3_rdata: rdata0=%h, expected a5a5", rd0[1]);
        end
        settle();
    endtask

    task automatic test_reset_mid;
        int acks;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0040;
        repeat (2) tick();
        tests++;
        if ({srd[1], sa[1]} !== {1'b0, 16'h0040}) begin
            fails++;
            $display("FAIL wait_hold: rd=%b addr=%h, expected 0 0040", srd[1], sa[1]);
        end
        reset_n = 1'b0;
        m1_req = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({ack0[i], ack1[i], srd[i], swr[i], sa[i], sd[i], rd0[i], rd1[i]} !== '0) begin
                fails++;
                $display("FAIL async_reset dut%0d: outputs %h, expected all 0", i,
                         {ack0[i], ack1[i], srd[i], swr[i], sa[i], sd[i], rd0[i], rd1[i]});
            end
        end
        repeat (2) tick();
        reset_n = 1'b1;
        acks = 0;
        repeat (8) begin
            tick();
            acks += int'(ack0[1]) + int'(ack1[1]) + int'(srd[1]) + int'(swr[1]);
        end
        tests++;
        if (acks != 0) begin
            fails++;
            $display("FAIL post_reset_quiet: %0d ack/strobe cycles, expected 0", acks);
        end
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0060; m0_wdata = 16'h0606;
        tick();
        tests++;
        if ({swr[1], sa[1], sd[1]} !== {1'b1, 16'h0060, 16'h0606}) begin
            fails++;
            $display("FAIL post_reset_strobe: wr=%b addr=%h dout=%h, expected 1 0060 0606", swr[1], sa[1], sd[1]);
        end
        tick();
        tests++;
        if (ack0[1] !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ack: ack0=%b, expected 1", ack0[1]);
        end
        settle();
    endtask

    task automatic test_write_keeps_rdata;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0070;
        tick();
        s_din = 16'h7777;
        tick();
        tests++;
        if ({ack0[0], rd0[0]} !== {1'b1, 16'h7777}) begin
            fails++;
            $display("FAIL prime_read: ack0=%b rdata0=%h, expected 1 7777", ack0[0], rd0[0]);
        end
        m0_req = 1'b0;
        s_din = 16'hFFFF;
        tick();
        tests++;
        if ({sa[0], sd[0], srd[0], swr[0]} !== '0) begin
            fails++;
            $display("FAIL idle_bus: addr=%h dout=%h rd=%b wr=%b, expected all 0", sa[0], sd[0], srd[0], swr[0]);
        end
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0050; m0_wdata = 16'h1234;
        tick();
        tests++;
        if ({swr[0], sa[0], sd[0]} !== {1'b1, 16'h0050, 16'h1234}) begin
            fails++;
            $display("FAIL keep_strobe: wr=%b addr=%h dout=%h, expected 1 0050 1234", swr[0], sa[0], sd[0]);
        end
        m0_addr = 16'hDEAD; m0_wdata = 16'hDEAD;
        tick();
        tests++;
        if ({ack0[0], rd0[0], sa[0], sd[0]} !== {1'b1, 16'h7777, 16'h0, 16'h0}) begin
            fails++;
            $display("FAIL keep_rdata: ack0=%b rdata0=%h addr=%h dout=%h, expected 1 7777 0000 0000",
                     ack0[0], rd0[0], sa[0], sd[0]);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_read_latency();
        test_reset_mid();
        test_write_keeps_rdata();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
